reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_if.sv | 55 +++++
 rtl/reorder_buffer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// +----------------------------------------------------------------------+
// | reorder_buffer_if                                                    |
// | Dispatch, writeback, flush and retirement signals of the ROB.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface reorder_buffer_if #(
  parameter int TAG_W = 4
);
  logic             alloc_valid;
  logic             alloc_dest_valid;
  logic [5:0]       alloc_preg;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             cmp1_valid;
  logic [TAG_W-1:0] cmp1_tag;
  logic [31:0]      cmp1_data;
  logic             cmp2_valid;
  logic [TAG_W-1:0] cmp2_tag;
  logic [31:0]      cmp2_data;
  logic             flush;
  logic             retire1;
  logic             retire2;
  logic [5:0]       write_addr1;
  logic [5:0]       write_addr2;
  logic [31:0]      write_data1;
  logic [31:0]      write_data2;
  logic [TAG_W:0]   rob_count;
  logic             rob_empty;

  // Dispatch / writeback side: drives requests, observes ROB status.
  modport master (
    output alloc_valid, alloc_dest_valid, alloc_preg,
    output cmp1_valid, cmp1_tag, cmp1_data,
    output cmp2_valid, cmp2_tag, cmp2_data,
    output flush,
    input  alloc_ready, alloc_tag,
    input  retire1, retire2, write_addr1, write_addr2, write_data1, write_data2,
    input  rob_count, rob_empty
  );

  // ROB side.
  modport slave (
    input  alloc_valid, alloc_dest_valid, alloc_preg,
    input  cmp1_valid, cmp1_tag, cmp1_data,
    input  cmp2_valid, cmp2_tag, cmp2_data,
    input  flush,
    output alloc_ready, alloc_tag,
    output retire1, retire2, write_addr1, write_addr2, write_data1, write_data2,
    output rob_count, rob_empty
  );
endinterface

`default_nettype wire

// File: rtl/reorder_buffer.sv
// +----------------------------------------------------------------------+
// | reorder_buffer                                                       |
// | Circular in-order retirement buffer: single allocate, two writeback  |
// | ports, up to two in-order retirements per cycle, flush.              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  wire logic        clk,
  input  wire logic        rstn,
  reorder_buffer_if.slave  bus
);

  localparam logic [TAG_W:0] C_FULL_COUNT = (TAG_W+1)'(DEPTH);

  // Per-entry state
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_dest;
  logic [5:0]       r_preg [DEPTH];
  logic [31:0]      r_data [DEPTH];

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic             r_retire1;
  logic             r_retire2;
  logic [5:0]       r_waddr1;
  logic [5:0]       r_waddr2;
  logic [31:0]      r_wdata1;
  logic [31:0]      r_wdata2;

  logic [TAG_W-1:0] w_head1;
  logic             w_alloc;
  logic             w_ret1;
  logic             w_ret2;
  logic             w_cmp1_hit;
  logic             w_cmp2_hit;
  logic [TAG_W:0]   w_nret;

  // Full check uses the registered count only, so a same-edge retire
  // never frees a slot for the allocation on that edge.
  assign w_head1    = r_head + TAG_W'(1);
  assign w_alloc    = bus.alloc_valid && (r_count != C_FULL_COUNT);
  assign w_ret1     = r_valid[r_head] && r_done[r_head];
  assign w_ret2     = w_ret1 && r_valid[w_head1] && r_done[w_head1];
  assign w_nret     = (TAG_W+1)'(w_ret1) + (TAG_W+1)'(w_ret2);
  // The tail entry is never valid while allocating, but the guard keeps
  // a same-edge completion from landing on the fresh entry explicitly.
  assign w_cmp1_hit = bus.cmp1_valid && r_valid[bus.cmp1_tag]
                      && !(w_alloc && (bus.cmp1_tag == r_tail));
  assign w_cmp2_hit = bus.cmp2_valid && r_valid[bus.cmp2_tag]
                      && !(w_alloc && (bus.cmp2_tag == r_tail));

  // Head/tail pointers and occupancy counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_nret[TAG_W-1:0];
      if (w_alloc) begin
        r_tail <= r_tail + TAG_W'(1);
      end
      r_count <= r_count + (TAG_W+1)'(w_alloc) - w_nret;
    end
  end

  // Entry valid/done flags: completions, then retire clears, then allocation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
      r_done  <= '0;
    end else if (bus.flush) begin
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (w_cmp1_hit) begin
        r_done[bus.cmp1_tag] <= 1'b1;
      end
      if (w_cmp2_hit) begin
        r_done[bus.cmp2_tag] <= 1'b1;
      end
      if (w_ret1) begin
        r_valid[r_head] <= 1'b0;
      end
      if (w_ret2) begin
        r_valid[w_head1] <= 1'b0;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
      end
    end
  end

  // Entry payload; only read once the valid/done flags qualify it, so no reset.
  // Port 2 is written last so it wins a same-tag collision.
  always_ff @(posedge clk) begin
    if (w_cmp1_hit) begin
      r_data[bus.cmp1_tag] <= bus.cmp1_data;
    end
    if (w_cmp2_hit) begin
      r_data[bus.cmp2_tag] <= bus.cmp2_data;
    end
    if (w_alloc) begin
      r_dest[r_tail] <= bus.alloc_dest_valid;
      r_preg[r_tail] <= bus.alloc_preg;
    end
  end

  // Registered register-file write strobes; zero unless a destination retires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_retire1 <= 1'b0;
      r_retire2 <= 1'b0;
      r_waddr1  <= '0;
      r_waddr2  <= '0;
      r_wdata1  <= '0;
      r_wdata2  <= '0;
    end else if (bus.flush) begin
      r_retire1 <= 1'b0;
      r_retire2 <= 1'b0;
      r_waddr1  <= '0;
      r_waddr2  <= '0;
      r_wdata1  <= '0;
      r_wdata2  <= '0;
    end else begin
      r_retire1 <= w_ret1 && r_dest[r_head];
      r_waddr1  <= (w_ret1 && r_dest[r_head]) ? r_preg[r_head] : 6'd0;
      r_wdata1  <= (w_ret1 && r_dest[r_head]) ? r_data[r_head] : 32'd0;
      r_retire2 <= w_ret2 && r_dest[w_head1];
      r_waddr2  <= (w_ret2 && r_dest[w_head1]) ? r_preg[w_head1] : 6'd0;
      r_wdata2  <= (w_ret2 && r_dest[w_head1]) ? r_data[w_head1] : 32'd0;
    end
  end

  assign bus.alloc_ready = (r_count != C_FULL_COUNT);
  assign bus.alloc_tag   = r_tail;
  assign bus.rob_count   = r_count;
  assign bus.rob_empty   = (r_count == '0);
  assign bus.retire1     = r_retire1;
  assign bus.retire2     = r_retire2;
  assign bus.write_addr1 = r_waddr1;
  assign bus.write_addr2 = r_waddr2;
  assign bus.write_data1 = r_wdata1;
  assign bus.write_data2 = r_wdata2;

endmodule

`default_nettype wire
